// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module  : player_pkg
// Brief   : Shared game-flow state encoding and USB HID keycode constants
//           for the player physics engine.
// Revision: 1.0  initial release
// ============================================================================
package player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_SPACE = 8'd44;

endpackage
`default_nettype wire

// File: rtl/plat_hit_detect.sv
`default_nettype none
// ============================================================================
// Module  : plat_hit_detect
// Brief   : Combinational landing test of the sprite foot against one
//           platform. A zero-width platform is treated as disabled.
// Revision: 1.0  initial release
// ============================================================================
module plat_hit_detect #(
    parameter int POS_W    = 11,
    parameter int LAND_TOL = 5
) (
    input  logic signed [POS_W:0]   mid,
    input  logic signed [POS_W:0]   foot_y,
    input  logic                    falling,
    input  logic [POS_W-1:0]        px,
    input  logic [POS_W-1:0]        py,
    input  logic [POS_W-1:0]        pw,
    output logic                    land
);

    localparam logic signed [POS_W:0] c_land_tol = (POS_W+1)'(LAND_TOL);

    logic signed [POS_W:0] w_left;
    logic signed [POS_W:0] w_right;
    logic signed [POS_W:0] w_top_lo;
    logic signed [POS_W:0] w_top_hi;

    // Foot must be inside the platform span and within the window around its top
    always_comb begin
        w_left   = $signed({1'b0, px});
        w_right  = w_left + $signed({1'b0, pw});
        w_top_lo = $signed({1'b0, py}) - c_land_tol;
        w_top_hi = $signed({1'b0, py}) + c_land_tol;
        land     = falling && (pw != '0)
                && (mid >= w_left) && (mid <= w_right)
                && (foot_y >= w_top_lo) && (foot_y < w_top_hi);
    end

endmodule
`default_nettype wire

// File: rtl/player_physics.sv
`default_nettype none
// ============================================================================
// Module  : player_physics
// Brief   : Per-frame player physics: keyboard motion with screen wrap,
//           divided gravity, platform landing/bounce, saturating score and
//           IDLE/PLAY/OVER game flow.
// Revision: 1.0  initial release
// ============================================================================
module player_physics
    import player_pkg::*;
#(
    parameter int NUM_PLAT = 3,
    parameter int POS_W    = 11,
    parameter int SCORE_W  = 7,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int SIZE_X   = 8,
    parameter int SIZE_Y   = 10,
    parameter int MID_X    = 4,
    parameter int X_STEP   = 1,
    parameter int JUMP_V   = 3,
    parameter int VY_MAX   = 4,
    parameter int GRAV_DIV = 8,
    parameter int LAND_TOL = 5,
    parameter int X_START  = 280,
    parameter int Y_START  = 460
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic [7:0]                keycode,
    input  logic [NUM_PLAT*POS_W-1:0] plat_x,
    input  logic [NUM_PLAT*POS_W-1:0] plat_y,
    input  logic [NUM_PLAT*POS_W-1:0] plat_w,
    output logic [POS_W-1:0]          player_x,
    output logic [POS_W-1:0]          player_y,
    output logic [SCORE_W-1:0]        score,
    output logic                      game_over,
    output logic                      playing
);

    localparam int c_div_w = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(GRAV_DIV - 1);
    localparam logic [POS_W-1:0]      c_x_start  = POS_W'(X_START);
    localparam logic [POS_W-1:0]      c_y_start  = POS_W'(Y_START);
    localparam logic [POS_W-1:0]      c_x_wrap_u = POS_W'(X_MAX + 1 - SIZE_X);
    localparam logic signed [POS_W:0] c_x_wrap   = (POS_W+1)'(X_MAX + 1 - SIZE_X);
    localparam logic signed [POS_W:0] c_y_max    = (POS_W+1)'(Y_MAX);
    localparam logic signed [POS_W:0] c_size_y   = (POS_W+1)'(SIZE_Y);
    localparam logic signed [POS_W:0] c_mid_x    = (POS_W+1)'(MID_X);
    localparam logic signed [POS_W:0] c_x_step   = (POS_W+1)'(X_STEP);
    localparam logic signed [POS_W:0] c_jump_v   = (POS_W+1)'(JUMP_V);
    localparam logic signed [POS_W:0] c_vy_max   = (POS_W+1)'(VY_MAX);
    localparam logic signed [POS_W:0] c_one      = (POS_W+1)'(1);
    localparam logic signed [POS_W:0] c_zero     = '0;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [POS_W-1:0]        r_x;
    logic [POS_W-1:0]        r_y;
    logic signed [POS_W:0]   r_vy;
    logic [SCORE_W-1:0]      r_score;
    logic [c_div_w-1:0]      r_div;

    logic [POS_W-1:0]        w_x_nx;
    logic [POS_W-1:0]        w_y_nx;
    logic signed [POS_W:0]   w_vy_nx;
    logic [SCORE_W-1:0]      w_score_nx;
    logic [c_div_w-1:0]      w_div_nx;

    logic signed [POS_W:0]   w_x_s;
    logic signed [POS_W:0]   w_y_s;
    logic signed [POS_W:0]   w_foot;
    logic signed [POS_W:0]   w_mid;
    logic signed [POS_W:0]   w_vx;
    logic signed [POS_W:0]   w_vy_new;
    logic signed [POS_W:0]   w_x_sum;
    logic signed [POS_W:0]   w_y_sum;
    logic [NUM_PLAT-1:0]     w_land;
    logic                    w_any_land;
    logic                    w_falling;

    assign w_x_s      = $signed({1'b0, r_x});
    assign w_y_s      = $signed({1'b0, r_y});
    assign w_foot     = w_y_s + c_size_y;
    assign w_mid      = w_x_s + c_mid_x;
    assign w_falling  = (r_vy > c_zero);
    assign w_any_land = |w_land;
    assign w_x_sum    = w_x_s + w_vx;

    generate
        for (genvar i = 0; i < NUM_PLAT; i++) begin : g_plat
            plat_hit_detect #(
                .POS_W    (POS_W),
                .LAND_TOL (LAND_TOL)
            ) u_hit (
                .mid     (w_mid),
                .foot_y  (w_foot),
                .falling (w_falling),
                .px      (plat_x[i*POS_W +: POS_W]),
                .py      (plat_y[i*POS_W +: POS_W]),
                .pw      (plat_w[i*POS_W +: POS_W]),
                .land    (w_land[i])
            );
        end
    endgenerate

    // Horizontal speed follows the key held this frame; no momentum
    always_comb begin
        w_vx = c_zero;
        if (keycode == KEY_A) begin
            w_vx = -c_x_step;
        end else if (keycode == KEY_D) begin
            w_vx = c_x_step;
        end
    end

    // Next-state and datapath update; position uses this edge's new velocity
    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_vy_nx    = r_vy;
        w_score_nx = r_score;
        w_div_nx   = r_div;
        w_vy_new   = r_vy;
        w_y_sum    = c_zero;
        case (r_state)
            PLAY: begin
                if (!w_any_land && (w_foot >= c_y_max)) begin
                    // Fell off the bottom: freeze everything where it is
                    w_state_nx = OVER;
                end else begin
                    if (w_any_land) begin
                        w_vy_new = -c_jump_v;
                        w_div_nx = '0;
                        if (r_score != '1) begin
                            w_score_nx = r_score + 1'b1;
                        end
                    end else if ((w_y_s <= c_zero) && (r_vy < c_zero)) begin
                        w_vy_new = c_zero;
                    end else begin
                        if (r_div == c_div_last) begin
                            w_div_nx = '0;
                            w_vy_new = (r_vy >= c_vy_max) ? c_vy_max : (r_vy + c_one);
                        end else begin
                            w_div_nx = r_div + 1'b1;
                        end
                    end
                    w_vy_nx = w_vy_new;
                    w_y_sum = w_y_s + w_vy_new;
                    // Upward motion never leaves the screen top
                    w_y_nx  = (w_y_sum < c_zero) ? '0 : w_y_sum[POS_W-1:0];
                    if (w_x_sum < c_zero) begin
                        w_x_nx = c_x_wrap_u;
                    end else if (w_x_sum > c_x_wrap) begin
                        w_x_nx = '0;
                    end else begin
                        w_x_nx = w_x_sum[POS_W-1:0];
                    end
                end
            end
            default: begin
                // IDLE and OVER hold still until SPACE starts a fresh run
                if (keycode == KEY_SPACE) begin
                    w_state_nx = PLAY;
                    w_x_nx     = c_x_start;
                    w_y_nx     = c_y_start;
                    w_vy_nx    = c_zero;
                    w_score_nx = '0;
                    w_div_nx   = '0;
                end
            end
        endcase
    end

    // State and datapath registers, one update per frame
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_x     <= c_x_start;
            r_y     <= c_y_start;
            r_vy    <= c_zero;
            r_score <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_vy    <= w_vy_nx;
            r_score <= w_score_nx;
            r_div   <= w_div_nx;
        end
    end

    assign player_x  = r_x;
    assign player_y  = r_y;
    assign score     = r_score;
    assign game_over = (r_state == OVER);
    assign playing   = (r_state == PLAY);

endmodule
`default_nettype wire

// File: tb/tb_player_physics.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_physics
// Brief   : Self-checking bench for player_physics with a frame-level
//           reference model feeding an expected-output queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_player_physics;

    logic        frame_clk;
    logic        Reset_n;
    logic [7:0]  keycode;
    logic [32:0] plat_x;
    logic [32:0] plat_y;
    logic [32:0] plat_w;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [6:0]  score;
    logic        game_over;
    logic        playing;

    player_physics u_dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .plat_x    (plat_x),
        .plat_y    (plat_y),
        .plat_w    (plat_w),
        .player_x  (player_x),
        .player_y  (player_y),
        .score     (score),
        .game_over (game_over),
        .playing   (playing)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int x;
        int y;
        int sc;
        int go;
        int pl;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: 0 IDLE, 1 PLAY, 2 OVER
    int m_st, m_x, m_y, m_vy, m_sc, m_div;
    int px[3], py[3], pw[3];

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_plat(input int i, input int x, input int y, input int w);
        px[i] = x;
        py[i] = y;
        pw[i] = w;
        plat_x[i*11 +: 11] = x[10:0];
        plat_y[i*11 +: 11] = y[10:0];
        plat_w[i*11 +: 11] = w[10:0];
    endtask

    task automatic model_reset();
        m_st = 0; m_x = 280; m_y = 460; m_vy = 0; m_sc = 0; m_div = 0;
    endtask

    task automatic model_step(input int key);
        int vx, foot, mid, nvy, nx, ny;
        bit land;
        if (m_st != 1) begin
            if (key == 44) begin
                m_st = 1; m_x = 280; m_y = 460; m_vy = 0; m_sc = 0; m_div = 0;
            end
            return;
        end
        vx   = (key == 4) ? -1 : (key == 7) ? 1 : 0;
        foot = m_y + 10;
        mid  = m_x + 4;
        land = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_vy > 0 && pw[i] != 0 && px[i] <= mid && mid <= px[i] + pw[i]
                && py[i] - 5 <= foot && foot < py[i] + 5)
                land = 1;
        end
        if (!land && foot >= 479) begin
            m_st = 2;
            return;
        end
        if (land) begin
            nvy   = -3;
            m_sc  = (m_sc < 127) ? m_sc + 1 : 127;
            m_div = 0;
        end else if (m_y <= 0 && m_vy < 0) begin
            nvy = 0;
        end else begin
            m_div = (m_div + 1) % 8;
            nvy   = (m_div == 0) ? ((m_vy + 1 > 4) ? 4 : m_vy + 1) : m_vy;
        end
        ny = m_y + nvy;
        if (ny < 0) ny = 0;
        nx = m_x + vx;
        if (nx < 0) nx = 632;
        else if (nx > 632) nx = 0;
        m_vy = nvy;
        m_x  = nx;
        m_y  = ny;
    endtask

    // Drive one frame, queue the model's expectation, compare after the edge
    task automatic run_frame(input int key);
        exp_t e;
        keycode = key[7:0];
        model_step(key);
        e.x = m_x; e.y = m_y; e.sc = m_sc;
        e.go = (m_st == 2) ? 1 : 0;
        e.pl = (m_st == 1) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge frame_clk);
        #1;
        e = exp_q.pop_front();
        check_val("x", int'(player_x), e.x);
        check_val("y", int'(player_y), e.y);
        check_val("score", int'(score), e.sc);
        check_val("game_over", int'(game_over), e.go);
        check_val("playing", int'(playing), e.pl);
    endtask

    initial begin
        Reset_n = 1'b0;
        keycode = 8'd0;
        plat_x  = '0;
        plat_y  = '0;
        plat_w  = '0;
        for (int i = 0; i < 3; i++) set_plat(i, 0, 0, 0);
        model_reset();
        @(posedge frame_clk);
        @(posedge frame_clk);
        #1;
        check_val("rst_x", int'(player_x), 280);
        check_val("rst_y", int'(player_y), 460);
        check_val("rst_score", int'(score), 0);
        check_val("rst_over", int'(game_over), 0);
        check_val("rst_play", int'(playing), 0);
        #2 Reset_n = 1'b1;
        #2;

        // idle holds, then start
        for (int i = 0; i < 3; i++) run_frame(0);
        run_frame(44);
        check_val("start_playing", int'(playing), 1);

        // gravity: nothing for 7 frames, then 1 px/frame
        for (int i = 0; i < 7; i++) run_frame(0);
        check_val("grav_hold_y", int'(player_y), 460);
        run_frame(0);
        check_val("grav_step1_y", int'(player_y), 461);
        run_frame(0);
        check_val("grav_step2_y", int'(player_y), 462);

        // fall off the bottom
        for (int n = 0; n < 100 && !game_over; n++) run_frame(0);
        check_val("over_reached", int'(game_over), 1);
        check_val("over_y", int'(player_y), 470);
        for (int i = 0; i < 3; i++) run_frame(4);
        check_val("over_frozen_x", int'(player_x), 280);

        // respawn
        run_frame(44);
        check_val("respawn_x", int'(player_x), 280);
        check_val("respawn_y", int'(player_y), 460);
        check_val("respawn_score", int'(score), 0);

        // single platform: first landing on frame 9 bounces immediately
        set_plat(0, 240, 470, 80);
        for (int i = 0; i < 8; i++) run_frame(0);
        check_val("pre_land_y", int'(player_y), 461);
        run_frame(0);
        check_val("land_y", int'(player_y), 458);
        check_val("land_score", int'(score), 1);

        // overlapping wide platform: one landing counts once
        set_plat(1, 0, 470, 639);
        for (int n = 0; n < 300 && score == 7'd1; n++) run_frame(0);
        check_val("dual_hit_score", int'(score), 2);

        // left wrap and right wrap
        for (int i = 0; i < 280; i++) run_frame(4);
        check_val("left_edge_x", int'(player_x), 0);
        run_frame(4);
        check_val("wrap_left_x", int'(player_x), 632);
        run_frame(7);
        check_val("wrap_right_x", int'(player_x), 0);
        run_frame(4);
        check_val("wrap_left2_x", int'(player_x), 632);

        // score saturation
        for (int n = 0; n < 12000 && score != 7'd127; n++) run_frame(0);
        check_val("score_max", int'(score), 127);
        for (int i = 0; i < 150; i++) run_frame(0);
        check_val("score_sat", int'(score), 127);
        check_val("still_playing", int'(playing), 1);

        // asynchronous reset in the middle of a frame
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_x", int'(player_x), 280);
        check_val("arst_y", int'(player_y), 460);
        check_val("arst_score", int'(score), 0);
        check_val("arst_play", int'(playing), 0);
        @(posedge frame_clk);
        #2 Reset_n = 1'b1;
        #1;
        run_frame(0);
        run_frame(44);
        check_val("restart_playing", int'(playing), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
